// File: rtl/muldiv_if.sv
// muldiv_if: handshake and operand/result bundle between the CPU control
// unit and the iterative multiply/divide unit.
//   start     request pulse from the control unit
//   op        00 mult, 01 multu, 10 div, 11 divu
//   a, b      rs / rt operands
//   busy      unit is not idle
//   done      one-cycle pulse, hi/lo valid
//   div_zero  one-cycle pulse with done when the divisor was zero
//   hi, lo    product halves, or remainder / quotient
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with MIPS HI/LO
// semantics (mult, multu, div, divu). Signed operations run on operand
// magnitudes and apply the sign correction in a final fix-up cycle.
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    muldiv_if slave: start/op/a/b in, busy/done/div_zero/hi/lo out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; latches operand magnitudes and result signs
// RUN   | one shift-add / shift-subtract step per cycle, WIDTH cycles
// FIX   | sign correction, hi/lo written on the way out
// DONE  | done (and div_zero if the divisor was 0) for one cycle
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic    clk,
   input  logic    reset,
   muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               div_q;
   logic               neg_q;
   logic               rem_neg_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH:0]     rem_q;
   logic               busy_q;
   logic               done_q;
   logic               div_zero_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               is_signed;
   logic               is_div;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH+1:0]   rem_sh;
   logic [WIDTH:0]     rem_diff;
   logic               div_ge;
   logic [WIDTH:0]     rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // op[0] set means unsigned, op[1] set means divide
   assign is_signed = ~bus.op[0];
   assign is_div    = bus.op[1];
   assign a_neg     = is_signed & bus.a[WIDTH-1];
   assign b_neg     = is_signed & bus.b[WIDTH-1];
   // the most-negative value maps onto itself, which is the correct magnitude
   // when read as unsigned
   assign a_abs     = a_neg ? -bus.a : bus.a;
   assign b_abs     = b_neg ? -bus.b : bus.b;

   // multiply: multiplier sits in the low half and shifts out to the right
   // while partial sums enter from the top
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // divide: dividend in the low half shifts out left into the remainder,
   // quotient bits shift in from the right
   assign rem_sh   = {rem_q, acc_q[WIDTH-1]};
   assign div_ge   = rem_sh >= {2'b00, opnd_q};
   assign rem_diff = rem_sh[WIDTH:0] - {1'b0, opnd_q};
   assign rem_next = div_ge ? rem_diff : rem_sh[WIDTH:0];
   assign quo_next = {acc_q[WIDTH-2:0], div_ge};

   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         div_q      <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q     <= 1'b0;
               div_zero_q <= 1'b0;
               if (bus.start) begin
                  div_q     <= is_div;
                  neg_q     <= a_neg ^ b_neg;
                  rem_neg_q <= a_neg;
                  opnd_q    <= b_abs;
                  acc_q     <= {{WIDTH{1'b0}}, a_abs};
                  rem_q     <= '0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  if (is_div && (bus.b == '0)) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     div_zero_q <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (div_q) begin
                  acc_q <= {acc_q[2*WIDTH-1:WIDTH], quo_next};
                  rem_q <= rem_next;
               end else begin
                  acc_q <= mul_next;
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               hi_q       <= div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
               lo_q       <= div_q ? quo_fix : prod_fix[WIDTH-1:0];
               state_q    <= S_DONE;
               done_q     <= 1'b1;
               div_zero_q <= 1'b0;
            end
            S_DONE: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               div_zero_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
endmodule
